fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem_array.sv | 42 ++++
 rtl/fifo_param.sv | 170 +++++++++++++++++
 tb/tb_fifo_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parameterised FIFO.
//   FIFO_WIDTH_DEFAULT - default data word width in bits
//   FIFO_DEPTH_DEFAULT - default word count (power of two, >= 4)
//   PARITY_MAX_WIDTH   - widest word even_parity() accepts (callers zero-extend)
//   even_parity()      - returns the bit that makes {bit, data} have even parity
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 63;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;
  localparam int unsigned PARITY_MAX_WIDTH   = 256;

  // Zero-extension does not change the XOR reduction, so one fixed-width helper
  // serves every word width up to PARITY_MAX_WIDTH.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_mem_array.sv
// fifo_mem_array: FIFO storage, one write port and one registered read port.
// The memory itself is not reset; only the read data register is.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data - synchronous write
//   rd_en/rd_addr      - read request; rd_data updates at the edge and holds otherwise
//   rd_data            - registered read data
module fifo_mem_array #(
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = 16,
  parameter int unsigned AddrBits = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [AddrBits-1:0] wr_addr,
  input  logic [Width-1:0]    wr_data,
  input  logic                rd_en,
  input  logic [AddrBits-1:0] rd_addr,
  output logic [Width-1:0]    rd_data
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with level flags, sticky error flags and a
// saturating drop counter. Storage lives in fifo_mem_array.
// Optional feature: define FIFO_PARITY_EN to store an even-parity bit per word
// and flag mismatches on read (parity_err); otherwise parity_err is tied to 0.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   data_in, write_n      - write data, active-low write request
//   read_n                - active-low read request
//   clear_flags_n         - active-low clear of overflow/underflow/parity_err/drop_count
//   almost_full_thresh    - fifo_almost_full when counter >= this
//   almost_empty_thresh   - fifo_almost_empty when counter <= this
//   data_out, data_valid  - registered read data, one-cycle pulse when updated
//   fifo_counter          - words stored (0..FIFO_DEPTH)
//   fifo_full/empty/almost_full/almost_empty - level status
//   overflow, underflow, parity_err - sticky errors
//   drop_count            - saturating count of rejected writes
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned FIFO_BITS  = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic                  clear_flags_n,
  input  logic [FIFO_BITS:0]    almost_full_thresh,
  input  logic [FIFO_BITS:0]    almost_empty_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [FIFO_BITS:0]    fifo_counter,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  parity_err,
  output logic [7:0]            drop_count
);

`ifdef FIFO_PARITY_EN
  localparam int unsigned MemWidth = FIFO_WIDTH + 1;
`else
  localparam int unsigned MemWidth = FIFO_WIDTH;
`endif

  localparam logic [FIFO_BITS:0] DepthCount = (FIFO_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_BITS:0] PtrOne     = (FIFO_BITS+1)'(1);

  logic [FIFO_BITS:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_BITS:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]  count;
  logic                write_accept, read_accept;
  logic                write_reject, read_reject;
  logic                data_valid_q;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic [7:0]          drop_count_q, drop_count_d;
  logic [MemWidth-1:0] mem_wdata, mem_rdata;

  // Extra pointer bit distinguishes full from empty, so the difference is the fill level.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DepthCount);

  assign read_accept  = !read_n && !fifo_empty;
  // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign write_accept = !write_n && (!fifo_full || read_accept);
  assign read_reject  = !read_n && !read_accept;
  assign write_reject = !write_n && !write_accept;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    drop_count_d = drop_count_q;

    if (write_accept) wr_ptr_d = wr_ptr_q + PtrOne;
    if (read_accept)  rd_ptr_d = rd_ptr_q + PtrOne;

    if (!clear_flags_n) begin
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      drop_count_d = '0;
    end
    // Error events are applied after the clear so a coincident event survives it.
    if (write_reject) begin
      overflow_d = 1'b1;
      if (drop_count_d != 8'hFF) drop_count_d = drop_count_d + 8'd1;
    end
    if (read_reject) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_valid_q <= read_accept;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  fifo_mem_array #(
    .Width    (MemWidth),
    .Depth    (FIFO_DEPTH),
    .AddrBits (FIFO_BITS)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (write_accept),
    .wr_addr (wr_ptr_q[FIFO_BITS-1:0]),
    .wr_data (mem_wdata),
    .rd_en   (read_accept),
    .rd_addr (rd_ptr_q[FIFO_BITS-1:0]),
    .rd_data (mem_rdata)
  );

`ifdef FIFO_PARITY_EN
  logic parity_hit;
  logic parity_err_q, parity_err_d;

  assign mem_wdata  = {even_parity(PARITY_MAX_WIDTH'(data_in)), data_in};
  // A stored word with even parity XOR-reduces to 0 including its parity bit.
  assign parity_hit = data_valid_q && (^mem_rdata);

  always_comb begin
    parity_err_d = parity_err_q;
    if (!clear_flags_n) parity_err_d = 1'b0;
    if (parity_hit)     parity_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  // The check result is visible alongside data_valid and then held by the sticky register.
  assign parity_err = parity_err_q || parity_hit;
`else
  assign mem_wdata  = data_in;
  assign parity_err = 1'b0;
`endif

  assign data_out          = mem_rdata[FIFO_WIDTH-1:0];
  assign data_valid        = data_valid_q;
  assign fifo_counter      = count;
  assign fifo_almost_full  = (count >= almost_full_thresh);
  assign fifo_almost_empty = (count <= almost_empty_thresh);
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;
  assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param at width 63, depth 16.
// Define FIFO_PARITY_EN for both bench and RTL to include the parity scenario.
module tb_fifo_param;

  localparam int unsigned W = 63;
  localparam int unsigned D = 16;
  localparam int unsigned B = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] data_in;
  logic         write_n, read_n, clear_flags_n;
  logic [B:0]   almost_full_thresh, almost_empty_thresh;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic [B:0]   fifo_counter;
  logic         fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic         overflow, underflow, parity_err;
  logic [7:0]   drop_count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_word;

  always #5 clk = ~clk;

  fifo_param #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .data_in             (data_in),
    .write_n             (write_n),
    .read_n              (read_n),
    .clear_flags_n       (clear_flags_n),
    .almost_full_thresh  (almost_full_thresh),
    .almost_empty_thresh (almost_empty_thresh),
    .data_out            (data_out),
    .data_valid          (data_valid),
    .fifo_counter        (fifo_counter),
    .fifo_full           (fifo_full),
    .fifo_empty          (fifo_empty),
    .fifo_almost_full    (fifo_almost_full),
    .fifo_almost_empty   (fifo_almost_empty),
    .overflow            (overflow),
    .underflow           (underflow),
    .parity_err          (parity_err),
    .drop_count          (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given requests; inputs return idle afterwards.
  task automatic op(input logic wr, input logic rd, input logic [W-1:0] d);
    write_n = ~wr;
    read_n  = ~rd;
    data_in = d;
    tick();
    write_n = 1'b1;
    read_n  = 1'b1;
  endtask

  initial begin
    reset_n             = 1'b0;
    write_n             = 1'b1;
    read_n              = 1'b1;
    clear_flags_n       = 1'b1;
    data_in             = '0;
    almost_full_thresh  = 5'd12;
    almost_empty_thresh = 5'd4;

    // Reset state
    #3;
    check("rst_counter", 64'(fifo_counter), 64'd0);
    check("rst_empty", 64'(fifo_empty), 64'd1);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_ae", 64'(fifo_almost_empty), 64'd1);
    check("rst_af", 64'(fifo_almost_full), 64'd0);
    check("rst_parity", 64'(parity_err), 64'd0);
    #10;
    reset_n = 1'b1;
    tick();

    // Fill with 0x1..0x10, watching the almost flags at each level
    for (int i = 1; i <= 16; i++) begin
      op(1'b1, 1'b0, W'(i));
      check("fill_count", 64'(fifo_counter), 64'(i));
      check("fill_af", 64'(fifo_almost_full), (i >= 12) ? 64'd1 : 64'd0);
      check("fill_ae", 64'(fifo_almost_empty), (i <= 4) ? 64'd1 : 64'd0);
    end
    check("full_flag", 64'(fifo_full), 64'd1);
    check("full_overflow", 64'(overflow), 64'd0);

    // 17th write is rejected
    op(1'b1, 1'b0, W'(64'h55));
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_count), 64'd1);
    check("ovf_count", 64'(fifo_counter), 64'd16);

    // Drain in order; 0x55 must not appear
    for (int i = 1; i <= 16; i++) begin
      op(1'b0, 1'b1, '0);
      check("drain_data", 64'(data_out), 64'(i));
      check("drain_valid", 64'(data_valid), 64'd1);
      check("drain_ae", 64'(fifo_almost_empty), ((16 - i) <= 4) ? 64'd1 : 64'd0);
    end
    check("drain_empty", 64'(fifo_empty), 64'd1);
    tick();
    check("idle_valid", 64'(data_valid), 64'd0);
    check("idle_hold", 64'(data_out), 64'h10);

    // Clear sticky flags
    clear_flags_n = 1'b0;
    tick();
    clear_flags_n = 1'b1;
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_drop", 64'(drop_count), 64'd0);

    // Read while empty with simultaneous write 0xAA: write only
    op(1'b1, 1'b1, W'(64'hAA));
    check("udf_flag", 64'(underflow), 64'd1);
    check("udf_count", 64'(fifo_counter), 64'd1);
    check("udf_valid", 64'(data_valid), 64'd0);
    check("udf_hold", 64'(data_out), 64'h10);
    op(1'b0, 1'b1, '0);
    check("aa_data", 64'(data_out), 64'hAA);
    check("aa_valid", 64'(data_valid), 64'd1);
    check("aa_empty", 64'(fifo_empty), 64'd1);

    // Prefill 8, then 40 simultaneous write/read pairs across the pointer wrap
    for (int k = 0; k < 8; k++) begin
      op(1'b1, 1'b0, W'(64'h100 + 64'(k)));
      model_q.push_back(W'(64'h100 + 64'(k)));
    end
    for (int i = 0; i < 40; i++) begin
      exp_word = model_q.pop_front();
      op(1'b1, 1'b1, W'(64'h200 + 64'(i)));
      model_q.push_back(W'(64'h200 + 64'(i)));
      check("pair_data", 64'(data_out), 64'(exp_word));
      check("pair_count", 64'(fifo_counter), 64'd8);
    end

    // Top up to full, then read+write while full: both accepted
    for (int k = 0; k < 8; k++) begin
      op(1'b1, 1'b0, W'(64'h300 + 64'(k)));
      model_q.push_back(W'(64'h300 + 64'(k)));
    end
    check("refull", 64'(fifo_full), 64'd1);
    exp_word = model_q.pop_front();
    op(1'b1, 1'b1, W'(64'h3FF));
    model_q.push_back(W'(64'h3FF));
    check("fullrw_data", 64'(data_out), 64'(exp_word));
    check("fullrw_count", 64'(fifo_counter), 64'd16);
    check("fullrw_ovf", 64'(overflow), 64'd0);

    // Clear coinciding with a rejected write: event wins
    clear_flags_n = 1'b0;
    op(1'b1, 1'b0, W'(64'h77));
    clear_flags_n = 1'b1;
    check("clrwin_ovf", 64'(overflow), 64'd1);
    check("clrwin_drop", 64'(drop_count), 64'd1);

    // Drop counter saturates at 255
    for (int i = 0; i < 300; i++) op(1'b1, 1'b0, W'(64'h66));
    check("drop_sat", 64'(drop_count), 64'd255);

    // Drain remaining contents in order, then one rejected read
    for (int i = 0; i < 16; i++) begin
      exp_word = model_q.pop_front();
      op(1'b0, 1'b1, '0);
      check("final_drain", 64'(data_out), 64'(exp_word));
    end
    op(1'b0, 1'b1, '0);
    check("final_udf", 64'(underflow), 64'd1);

    // Reach counter 7 with non-zero data_out, then reset mid-burst
    for (int k = 0; k < 8; k++) op(1'b1, 1'b0, W'(64'h400 + 64'(k)));
    op(1'b0, 1'b1, '0);
    check("pre_rst_count", 64'(fifo_counter), 64'd7);
    check("pre_rst_data", 64'(data_out), 64'h400);
    write_n = 1'b0;
    read_n  = 1'b0;
    data_in = W'(64'h999);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(fifo_counter), 64'd0);
    check("mid_rst_data", 64'(data_out), 64'd0);
    check("mid_rst_valid", 64'(data_valid), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    check("mid_rst_udf", 64'(underflow), 64'd0);
    check("mid_rst_drop", 64'(drop_count), 64'd0);
    check("mid_rst_empty", 64'(fifo_empty), 64'd1);
    write_n = 1'b1;
    read_n  = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_count", 64'(fifo_counter), 64'd0);

`ifdef FIFO_PARITY_EN
    // Corrupt bit 0 of stored word 3 and expect parity_err with its data_valid
    for (int k = 0; k < 4; k++) op(1'b1, 1'b0, W'(64'h500 + 64'(k)));
    dut.u_mem.mem_q[3][0] = ~dut.u_mem.mem_q[3][0];
    for (int k = 0; k < 3; k++) begin
      op(1'b0, 1'b1, '0);
      check("par_clean", 64'(parity_err), 64'd0);
    end
    op(1'b0, 1'b1, '0);
    check("par_valid", 64'(data_valid), 64'd1);
    check("par_err", 64'(parity_err), 64'd1);
    tick();
    check("par_sticky", 64'(parity_err), 64'd1);
    clear_flags_n = 1'b0;
    tick();
    clear_flags_n = 1'b1;
    check("par_clear", 64'(parity_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
